// File: rtl/roc_encoder.sv
// Rank-order encoder: emits pixel indices by descending intensity over an AER handshake.
// Optional feature: define ROC_EMIT_ZERO_EN to also emit zero-valued pixels.
module roc_encoder #(
    parameter int IMAGE_SIZE      = 6,
    parameter int IMAGE_SIZE_BITS = 3,
    parameter int PIXEL_MAX_VALUE = 10,
    parameter int PIXEL_BITS      = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [PIXEL_BITS-1:0] IMAGE [0:IMAGE_SIZE-1],
    input  logic                  NEW_IMAGE,
    input  logic                  AERIN_CTRL_BUSY,
    input  logic                  INFERENCE_RDY,
    output logic [9:0]            NEXT_INDEX,
    output logic                  FOUND_NEXT_INDEX,
    output logic                  ENCODER_RDY
);

    localparam int IW = (IMAGE_SIZE_BITS > 0) ? IMAGE_SIZE_BITS : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(IMAGE_SIZE - 1);
    localparam logic [PIXEL_BITS-1:0] MAXV = PIXEL_BITS'(PIXEL_MAX_VALUE);
`ifdef ROC_EMIT_ZERO_EN
    localparam logic [PIXEL_BITS-1:0] LOWV = '0;
`else
    localparam logic [PIXEL_BITS-1:0] LOWV = PIXEL_BITS'(1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_WAIT_BUSY_HI,
        S_WAIT_BUSY_LO,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [PIXEL_BITS-1:0] r_pix [0:IMAGE_SIZE-1];
    logic [IW-1:0]         r_idx;
    logic [PIXEL_BITS-1:0] r_val;
    logic [9:0]            r_next_index;
    logic                  r_found;
    logic                  r_rdy;

    logic w_match;
    logic w_last_idx;
    logic w_last_val;
    logic w_advance;

    assign w_match    = (r_pix[r_idx] == r_val);
    assign w_last_idx = (r_idx == LAST_IDX);
    assign w_last_val = (r_val == LOWV);
    // A non-matching compare and a completed acknowledge both step the scan.
    assign w_advance  = ((r_state == S_SCAN) && !w_match) ||
                        ((r_state == S_WAIT_BUSY_LO) && !AERIN_CTRL_BUSY);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_val        <= '0;
            r_next_index <= '0;
            r_found      <= 1'b0;
            r_rdy        <= 1'b1;
            for (int i = 0; i < IMAGE_SIZE; i++) begin
                r_pix[i] <= '0;
            end
        end else begin
            r_found <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (NEW_IMAGE) begin
                        for (int i = 0; i < IMAGE_SIZE; i++) begin
                            r_pix[i] <= (IMAGE[i] > MAXV) ? MAXV : IMAGE[i];
                        end
                        r_val   <= MAXV;
                        r_idx   <= '0;
                        r_rdy   <= 1'b0;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_match) begin
                        r_next_index <= 10'(r_idx);
                        r_found      <= 1'b1;
                        r_state      <= S_WAIT_BUSY_HI;
                    end
                end
                S_WAIT_BUSY_HI: begin
                    if (AERIN_CTRL_BUSY) begin
                        r_state <= S_WAIT_BUSY_LO;
                    end
                end
                S_WAIT_BUSY_LO: begin
                    r_state <= S_WAIT_BUSY_LO;
                end
                S_DONE: begin
                    if (INFERENCE_RDY) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_rdy   <= 1'b1;
                end
            endcase

            if (w_advance) begin
                if (w_last_idx) begin
                    if (w_last_val) begin
                        r_state <= S_DONE;
                        r_rdy   <= 1'b1;
                    end else begin
                        r_idx   <= '0;
                        r_val   <= r_val - 1'b1;
                        r_state <= S_SCAN;
                    end
                end else begin
                    r_idx   <= r_idx + 1'b1;
                    r_state <= S_SCAN;
                end
            end
        end
    end

    assign NEXT_INDEX       = r_next_index;
    assign FOUND_NEXT_INDEX = r_found;
    assign ENCODER_RDY      = r_rdy;

endmodule

// File: tb/tb_roc_encoder.sv
// Scoreboard bench for roc_encoder: a rank-order model fills a queue, a monitor
// pops it on every FOUND_NEXT_INDEX strobe, and a responder plays the AER link.
module tb_roc_encoder;

    localparam int N    = 6;
    localparam int MAXV = 10;
`ifdef ROC_EMIT_ZERO_EN
    localparam int LOW = 0;
`else
    localparam int LOW = 1;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] IMAGE [0:N-1];
    logic       NEW_IMAGE = 1'b0;
    logic       BUSY = 1'b0;
    logic       INF = 1'b0;
    logic [9:0] NEXT_INDEX;
    logic       FOUND;
    logic       RDY;

    roc_encoder #(
        .IMAGE_SIZE(N),
        .IMAGE_SIZE_BITS(3),
        .PIXEL_MAX_VALUE(MAXV),
        .PIXEL_BITS(4)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .IMAGE(IMAGE),
        .NEW_IMAGE(NEW_IMAGE),
        .AERIN_CTRL_BUSY(BUSY),
        .INFERENCE_RDY(INF),
        .NEXT_INDEX(NEXT_INDEX),
        .FOUND_NEXT_INDEX(FOUND),
        .ENCODER_RDY(RDY)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    int n_strobe = 0;
    int q[$];
    int pre_dly  = 1;
    int post_dly = 3;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: every pixel, clamped, listed by value high to low, ties by index.
    function automatic void model();
        int c;
        for (int v = MAXV; v >= LOW; v--) begin
            for (int i = 0; i < N; i++) begin
                c = (int'(IMAGE[i]) > MAXV) ? MAXV : int'(IMAGE[i]);
                if (c == v) q.push_back(i);
            end
        end
    endfunction

    always @(negedge CLK) begin
        int e;
        if (!RST && FOUND) begin
            n_strobe++;
            if (q.size() == 0) begin
                chk("unexpected_strobe", int'(NEXT_INDEX), -1);
            end else begin
                e = q.pop_front();
                chk("next_index", int'(NEXT_INDEX), e);
            end
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            if (FOUND && !RST) begin
                repeat (pre_dly) @(posedge CLK);
                #1 BUSY = 1'b1;
                repeat (post_dly) @(posedge CLK);
                #1 BUSY = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic set_img(input int a, b, c, d, e, f);
        IMAGE[0] = 4'(a); IMAGE[1] = 4'(b); IMAGE[2] = 4'(c);
        IMAGE[3] = 4'(d); IMAGE[4] = 4'(e); IMAGE[5] = 4'(f);
    endtask

    task automatic rand_img();
        for (int i = 0; i < N; i++) IMAGE[i] = 4'($urandom_range(0, 15));
    endtask

    task automatic start_image();
        model();
        NEW_IMAGE = 1'b1;
        @(posedge CLK);
        #1 NEW_IMAGE = 1'b0;
        @(negedge CLK);
        chk("rdy_drop", int'(RDY), 0);
    endtask

    task automatic wait_done(input int bound);
        int c = 0;
        while (!RDY && c < bound) begin
            @(negedge CLK);
            c++;
        end
        chk("done_in_time", int'(c < bound), 1);
        chk("all_emitted", q.size(), 0);
        q.delete();
    endtask

    task automatic wait_strobes(input int target, input int bound);
        int c = 0;
        while (n_strobe < target && c < bound) begin
            @(negedge CLK);
            c++;
        end
        chk("strobe_in_time", int'(c < bound), 1);
    endtask

    task automatic release_done();
        INF = 1'b1;
        @(posedge CLK);
        #1 INF = 1'b0;
        @(negedge CLK);
        chk("idle_rdy", int'(RDY), 1);
    endtask

    task automatic run_image();
        start_image();
        wait_done(2000);
        release_done();
    endtask

    initial begin
        int base;
        set_img(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("reset_rdy", int'(RDY), 1);
        chk("reset_found", int'(FOUND), 0);
        chk("reset_index", int'(NEXT_INDEX), 0);

        set_img(3, 10, 0, 7, 3, 1);
        run_image();

        set_img(15, 0, 0, 0, 0, 10);
        run_image();

        // Link stalls before acknowledging the first emission.
        pre_dly = 20;
        set_img(5, 9, 2, 9, 0, 1);
        base = n_strobe;
        start_image();
        wait_strobes(base + 1, 200);
        repeat (15) @(negedge CLK);
        chk("stall_rdy", int'(RDY), 0);
        chk("stall_strobes", n_strobe, base + 1);
        wait_done(2000);
        release_done();
        pre_dly = 1;

        // NEW_IMAGE during scan is ignored, then reset aborts mid-acknowledge.
        set_img(2, 4, 6, 8, 1, 3);
        base = n_strobe;
        start_image();
        set_img(10, 10, 10, 10, 10, 10);
        NEW_IMAGE = 1'b1;
        @(negedge CLK);
        NEW_IMAGE = 1'b0;
        post_dly = 6;
        wait_strobes(base + 2, 500);
        repeat (4) @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        chk("abort_rdy", int'(RDY), 1);
        chk("abort_found", int'(FOUND), 0);
        chk("abort_index", int'(NEXT_INDEX), 0);
        q.delete();
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (10) @(negedge CLK);
        post_dly = 3;
        set_img(1, 0, 9, 9, 4, 0);
        run_image();

        // DONE ignores NEW_IMAGE until inference completes.
        set_img(7, 7, 2, 0, 8, 1);
        start_image();
        wait_done(2000);
        base = n_strobe;
        rand_img();
        NEW_IMAGE = 1'b1;
        @(negedge CLK);
        NEW_IMAGE = 1'b0;
        repeat (5) @(negedge CLK);
        chk("done_hold_rdy", int'(RDY), 1);
        chk("done_no_strobe", n_strobe, base);
        release_done();
        set_img(0, 6, 6, 11, 0, 3);
        run_image();

        for (int k = 0; k < 8; k++) begin
            pre_dly  = $urandom_range(1, 3);
            post_dly = $urandom_range(1, 4);
            rand_img();
            run_image();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
